shift_sequencer: RTL and testbench

Multi-cycle shift/rotate controller for the 8-bit ALU path. It accepts a start request with an operand, an amount and an opcode, and reduces the amount to an effective step count. It then iterates a single-bit shift/rotate step once per clock, and returns the result with a one-cycle done pulse. It sits beside the ALU as a compact alternative to the barrel rotator: the datapath is one step per cycle, and the sequencing logic lives in this block.

---
 rtl/shift_sequencer_pkg.sv | 33 +++
 rtl/shift_step.sv | 22 ++
 rtl/shift_sequencer.sv | 88 ++++++++
 tb/tb_shift_sequencer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift/rotate sequencer:
// widths, opcode encodings, FSM states and the step-count reduction.
package shift_sequencer_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [2:0] OP_ROR = 3'b000;
  localparam logic [2:0] OP_ROL = 3'b001;
  localparam logic [2:0] OP_LSL = 3'b010;
  localparam logic [2:0] OP_LSR = 3'b011;
  localparam logic [2:0] OP_ASR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

  // Rotates wrap every WIDTH steps; shifts saturate once every bit is gone.
  function automatic logic [CNT_W-1:0] eff_count(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] amt);
    logic [CNT_W-1:0] n;
    n = '0;
    case (op)
      OP_ROR, OP_ROL:         n = {1'b0, amt[2:0]};
      OP_LSL, OP_LSR, OP_ASR: n = (amt >= WIDTH'(8)) ? CNT_W'(8) : amt[CNT_W-1:0];
      default:                n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Purely combinational single-bit shift/rotate step for the sequencer datapath.
module shift_step
  import shift_sequencer_pkg::*;
(
  input  logic [WIDTH-1:0] work_i,
  input  logic [2:0]       opcode_i,
  output logic [WIDTH-1:0] step_o
);

  always_comb begin
    step_o = work_i;
    case (opcode_i)
      OP_ROR:  step_o = {work_i[0], work_i[WIDTH-1:1]};
      OP_ROL:  step_o = {work_i[WIDTH-2:0], work_i[WIDTH-1]};
      OP_LSL:  step_o = {work_i[WIDTH-2:0], 1'b0};
      OP_LSR:  step_o = {1'b0, work_i[WIDTH-1:1]};
      OP_ASR:  step_o = {work_i[WIDTH-1], work_i[WIDTH-1:1]};
      default: step_o = work_i;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller: captures an operand, reduces the amount
// to a step count, applies one single-bit step per clock and pulses DONE.
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       OPCODE,
  input  logic [WIDTH-1:0] DATA,
  input  logic [WIDTH-1:0] AMOUNT,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic             DONE
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       opcode_q, opcode_d;
  logic [CNT_W-1:0] start_cnt;
  logic [WIDTH-1:0] stepped;

  assign start_cnt = eff_count(OPCODE, AMOUNT);

  shift_step u_step (
    .work_i   (work_q),
    .opcode_i (opcode_q),
    .step_o   (stepped)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      result_q <= '0;
      count_q  <= '0;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      count_q  <= count_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    count_d  = count_q;
    opcode_d = opcode_q;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (START) begin
          work_d   = DATA;
          opcode_d = OPCODE;
          if (start_cnt == '0) begin
            state_d  = ST_FIN;
            result_d = DATA;
          end else begin
            state_d = ST_RUN;
            count_d = start_cnt;
          end
        end else if (state_q == ST_FIN) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // START is deliberately not looked at here: an in-flight op is never disturbed.
        work_d  = stepped;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d  = ST_FIN;
          result_d = stepped;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign RESULT = result_q;
  assign BUSY   = (state_q == ST_RUN);
  assign DONE   = (state_q == ST_FIN);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: a table of hand-computed vectors plus
// hand-written sequences for mid-run START, back-to-back ops and reset.
module tb_shift_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [2:0] OPCODE;
  logic [7:0] DATA;
  logic [7:0] AMOUNT;
  logic [7:0] RESULT;
  logic       BUSY;
  logic       DONE;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  shift_sequencer dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .OPCODE (OPCODE),
    .DATA   (DATA),
    .AMOUNT (AMOUNT),
    .RESULT (RESULT),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic [7:0] amt;
    logic [7:0] exp_res;
    int         exp_lat;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one op from IDLE or FIN and follows it to its DONE cycle.
  // junk_at >= 0 pulses a conflicting START that many cycles after capture.
  task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] data,
                        input logic [7:0] amt, input logic [7:0] exp_res,
                        input int exp_lat, input int junk_at);
    logic [7:0] prev_res;
    int lat;
    prev_res = RESULT;
    START = 1'b1; OPCODE = op; DATA = data; AMOUNT = amt;
    @(posedge CLK); #1;
    START = 1'b0;
    lat = 0;
    while (!DONE && lat < 20) begin
      chk({name, " busy"}, int'(BUSY), 1);
      chk({name, " held"}, int'(RESULT), int'(prev_res));
      if (lat == junk_at) begin
        START = 1'b1; OPCODE = 3'b110; DATA = 8'h00; AMOUNT = 8'h00;
      end else begin
        START = 1'b0;
      end
      @(posedge CLK); #1;
      lat++;
    end
    START = 1'b0;
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " result"}, int'(RESULT), int'(exp_res));
    chk({name, " busy&done"}, int'(BUSY && DONE), 0);
    $display("op=%0d data=0x%02h amt=%0d -> result=0x%02h after %0d edges", op, data, amt, RESULT, lat);
  endtask

  task automatic after_done(input string name, input logic [7:0] exp_res);
    @(posedge CLK); #1;
    chk({name, " done pulse"}, int'(DONE), 0);
    chk({name, " idle busy"}, int'(BUSY), 0);
    chk({name, " result kept"}, int'(RESULT), int'(exp_res));
  endtask

  initial begin
    tbl[0]  = '{3'b000, 8'h81, 8'd1,   8'hC0, 1};
    tbl[1]  = '{3'b001, 8'h81, 8'd11,  8'h0C, 3};
    tbl[2]  = '{3'b000, 8'h81, 8'd8,   8'h81, 0};
    tbl[3]  = '{3'b100, 8'h90, 8'd200, 8'hFF, 8};
    tbl[4]  = '{3'b011, 8'h90, 8'd9,   8'h00, 8};
    tbl[5]  = '{3'b010, 8'h90, 8'd2,   8'h40, 2};
    tbl[6]  = '{3'b110, 8'h5A, 8'd7,   8'h5A, 0};
    tbl[7]  = '{3'b000, 8'h01, 8'd7,   8'h02, 7};
    tbl[8]  = '{3'b010, 8'hFF, 8'd8,   8'h00, 8};
    tbl[9]  = '{3'b100, 8'h40, 8'd3,   8'h08, 3};
    tbl[10] = '{3'b101, 8'hC3, 8'd255, 8'hC3, 0};
    tbl[11] = '{3'b111, 8'h3C, 8'd0,   8'h3C, 0};
    tbl[12] = '{3'b011, 8'hF0, 8'd0,   8'hF0, 0};
    tbl[13] = '{3'b001, 8'h80, 8'h0F,  8'h40, 7};

    RESET = 1'b1; START = 1'b0; OPCODE = 3'b000; DATA = 8'h00; AMOUNT = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    chk("reset result", int'(RESULT), 0);
    chk("reset busy", int'(BUSY), 0);
    chk("reset done", int'(DONE), 0);

    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].data, tbl[i].amt,
             tbl[i].exp_res, tbl[i].exp_lat, -1);
      after_done($sformatf("vec%0d", i), tbl[i].exp_res);
    end

    // Conflicting START during RUN must not disturb the op in flight.
    run_op("midrun", 3'b001, 8'h81, 8'd3, 8'h0C, 3, 0);
    after_done("midrun", 8'h0C);
    run_op("midrun2", 3'b010, 8'h90, 8'd2, 8'h40, 2, 1);
    after_done("midrun2", 8'h40);

    // Back-to-back: second START sampled during the first op's FIN cycle.
    run_op("b2b first", 3'b010, 8'h90, 8'd2, 8'h40, 2, -1);
    run_op("b2b second", 3'b000, 8'h81, 8'd1, 8'hC0, 1, -1);
    run_op("b2b third", 3'b110, 8'hA5, 8'd3, 8'hA5, 0, -1);
    after_done("b2b", 8'hA5);

    // RESET on the 2nd RUN edge of an ASR by 5.
    START = 1'b1; OPCODE = 3'b100; DATA = 8'h90; AMOUNT = 8'd5;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("rst busy", int'(BUSY), 0);
    chk("rst done", int'(DONE), 0);
    chk("rst result", int'(RESULT), 0);
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("rst quiet done c%0d", k), int'(DONE), 0);
      chk($sformatf("rst quiet result c%0d", k), int'(RESULT), 0);
    end
    $display("reset mid-RUN -> result=0x%02h busy=%0b done=%0b", RESULT, BUSY, DONE);

    // RESET wins over a simultaneous START.
    run_op("pre", 3'b110, 8'h77, 8'd0, 8'h77, 0, -1);
    START = 1'b1; RESET = 1'b1; OPCODE = 3'b110; DATA = 8'h33; AMOUNT = 8'd0;
    @(posedge CLK); #1;
    START = 1'b0; RESET = 1'b0;
    chk("rst+start done", int'(DONE), 0);
    chk("rst+start busy", int'(BUSY), 0);
    chk("rst+start result", int'(RESULT), 0);
    $display("reset with START -> result=0x%02h busy=%0b done=%0b", RESULT, BUSY, DONE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
